// File: rtl/ibex_fp_pkg.sv
// Shared types and constants for the FP writeback path.
// fp_wb_entry_t is the default-width shape of one buffered FPU result.
package ibex_fp_pkg;

    localparam int unsigned DefaultDataWidth = 16;

    typedef struct packed {
        logic [4:0]                  rd;
        logic [DefaultDataWidth-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/ibex_fp_wb_fifo.sv
// In-order result buffer between the FPU and the writeback arbiter.
// Depth must be a power of two so the pointers wrap naturally.
module ibex_fp_wb_fifo
    import ibex_fp_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = fp_wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;
    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/ibex_fp_writeback.sv
// FP register file writeback arbiter: LSU loads beat buffered FPU results,
// with an empty-FIFO bypass, plus a pending-destination scoreboard.
module ibex_fp_writeback
    import ibex_fp_pkg::*;
#(
    parameter int unsigned DataWidth = DefaultDataWidth,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [4:0]           fpu_rd_i,
    input  logic [DataWidth-1:0] fpu_result_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_rd_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic [4:0]           fp_waddr_a_o,
    output logic [DataWidth-1:0] fp_wdata_a_o,
    output logic                 fp_we_a_o,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic                 hazard_o,
    output logic                 err_o
);

    typedef struct packed {
        logic [4:0]           rd;
        logic [DataWidth-1:0] data;
    } wb_entry_t;

    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    wb_entry_t fifo_head, fpu_entry, sel_entry;
    logic      fpu_hs, sel_valid;

    logic                 we_q, we_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [31:0]          pending_q, pending_d;

    // Ready depends only on FIFO state, never on fpu_valid_i.
    assign fpu_ready_o = !fifo_full;
    assign fpu_hs      = fpu_valid_i && fpu_ready_o;
    assign fpu_entry   = '{rd: fpu_rd_i, data: fpu_result_i};

    ibex_fp_wb_fifo #(
        .Depth   (FifoDepth),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fpu_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_entry = fpu_entry;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (lsu_valid_i) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: lsu_rd_i, data: lsu_rdata_i};
            fifo_push = fpu_hs;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = fpu_hs;
        end else if (fpu_hs) begin
            sel_valid = 1'b1;
            sel_entry = fpu_entry;
        end
    end

    always_comb begin
        we_d    = sel_valid && (sel_entry.rd != 5'd0);
        waddr_d = sel_valid ? sel_entry.rd : waddr_q;
        wdata_d = sel_valid ? sel_entry.data : wdata_q;
        err_d   = (we_d && !pending_q[sel_entry.rd]) ||
                  (issue_valid_i && (issue_rd_i != 5'd0) && pending_q[issue_rd_i]);
        // The clear follows the registered write; a same-edge issue re-sets the bit.
        pending_d = pending_q;
        if (we_q) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pending_q <= pending_d;
        end
    end

    assign fp_we_a_o    = we_q;
    assign fp_waddr_a_o = waddr_q;
    assign fp_wdata_a_o = wdata_q;
    assign err_o        = err_q;
    assign hazard_o     = ((rs1_addr_i != 5'd0) && pending_q[rs1_addr_i]) ||
                          ((rs2_addr_i != 5'd0) && pending_q[rs2_addr_i]);

endmodule

// File: tb/tb_ibex_fp_writeback.sv
// Self-checking bench for ibex_fp_writeback: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_ibex_fp_writeback;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 2;

    logic          clk, rst_ni;
    logic          issue_valid_i;
    logic [4:0]    issue_rd_i;
    logic          fpu_valid_i, fpu_ready_o;
    logic [4:0]    fpu_rd_i;
    logic [DW-1:0] fpu_result_i;
    logic          lsu_valid_i;
    logic [4:0]    lsu_rd_i;
    logic [DW-1:0] lsu_rdata_i;
    logic [4:0]    fp_waddr_a_o;
    logic [DW-1:0] fp_wdata_a_o;
    logic          fp_we_a_o;
    logic [4:0]    rs1_addr_i, rs2_addr_i;
    logic          hazard_o, err_o;

    ibex_fp_writeback #(
        .DataWidth (DW),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_ready_o   (fpu_ready_o),
        .fpu_rd_i      (fpu_rd_i),
        .fpu_result_i  (fpu_result_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_rdata_i   (lsu_rdata_i),
        .fp_waddr_a_o  (fp_waddr_a_o),
        .fp_wdata_a_o  (fp_wdata_a_o),
        .fp_we_a_o     (fp_we_a_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .hazard_o      (hazard_o),
        .err_o         (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state
    ent_t          mq[$];
    bit   [31:0]   pend;
    bit            exp_we, exp_err;
    logic [4:0]    exp_waddr;
    logic [DW-1:0] exp_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i = 1'b0; issue_rd_i = '0;
        fpu_valid_i = 1'b0; fpu_rd_i = '0; fpu_result_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_rdata_i = '0;
    endtask

    // One clock: drive inputs at the falling edge, check combinational
    // outputs, predict, then check registered outputs just after the rising edge.
    task automatic cycle(input bit iv, input logic [4:0] ird,
                         input bit fv, input logic [4:0] frd, input logic [DW-1:0] fd,
                         input bit lv, input logic [4:0] lrd, input logic [DW-1:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        bit   m_ready, hs, sel_v, n_err;
        ent_t sel;
        issue_valid_i = iv;  issue_rd_i = ird;
        fpu_valid_i   = fv;  fpu_rd_i   = frd; fpu_result_i = fd;
        lsu_valid_i   = lv;  lsu_rd_i   = lrd; lsu_rdata_i  = ld;
        rs1_addr_i    = r1;  rs2_addr_i = r2;
        #1;
        m_ready = (mq.size() < DEPTH);
        check_eq("ready", {31'b0, fpu_ready_o}, {31'b0, m_ready});
        check_eq("hazard", {31'b0, hazard_o},
                 {31'b0, ((r1 != 0) && pend[r1]) || ((r2 != 0) && pend[r2])});
        hs    = fv && m_ready;
        sel_v = 1'b0;
        sel   = '0;
        if (lv) begin
            sel_v = 1'b1;
            sel   = '{rd: lrd, data: ld};
            if (hs) mq.push_back('{rd: frd, data: fd});
        end else if (mq.size() > 0) begin
            sel_v = 1'b1;
            sel   = mq.pop_front();
            if (hs) mq.push_back('{rd: frd, data: fd});
        end else if (hs) begin
            sel_v = 1'b1;
            sel   = '{rd: frd, data: fd};
        end
        n_err = (sel_v && (sel.rd != 0) && !pend[sel.rd]) ||
                (iv && (ird != 0) && pend[ird]);
        if (exp_we) pend[exp_waddr] = 1'b0;
        if (iv && (ird != 0)) pend[ird] = 1'b1;
        exp_we  = sel_v && (sel.rd != 0);
        exp_err = n_err;
        if (sel_v) begin
            exp_waddr = sel.rd;
            exp_wdata = sel.data;
        end
        @(posedge clk);
        #1;
        check_eq("we", {31'b0, fp_we_a_o}, {31'b0, exp_we});
        if (exp_we) begin
            check_eq("waddr", {27'b0, fp_waddr_a_o}, {27'b0, exp_waddr});
            check_eq("wdata", {16'b0, fp_wdata_a_o}, {16'b0, exp_wdata});
        end
        check_eq("err", {31'b0, err_o}, {31'b0, exp_err});
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    task automatic issue(input logic [4:0] rd);
        cycle(1, rd, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset(input logic [4:0] probe);
        @(negedge clk);
        idle_inputs();
        rs1_addr_i = probe;
        rs2_addr_i = '0;
        rst_ni = 1'b0;
        #1;
        check_eq("rst_we",     {31'b0, fp_we_a_o},    32'd0);
        check_eq("rst_waddr",  {27'b0, fp_waddr_a_o}, 32'd0);
        check_eq("rst_wdata",  {16'b0, fp_wdata_a_o}, 32'd0);
        check_eq("rst_err",    {31'b0, err_o},        32'd0);
        check_eq("rst_ready",  {31'b0, fpu_ready_o},  32'd1);
        check_eq("rst_hazard", {31'b0, hazard_o},     32'd0);
        mq.delete();
        pend      = '0;
        exp_we    = 1'b0;
        exp_err   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        apply_reset(5'd0);

        // Bypass with empty FIFO; hazard persists through the write cycle.
        issue(5'd3);
        cycle(0, 0, 1, 5'd3, 16'h3C00, 0, 0, 0, 5'd3, 0);
        check_eq("byp_we",    {31'b0, fp_we_a_o},    32'd1);
        check_eq("byp_waddr", {27'b0, fp_waddr_a_o}, 32'd3);
        check_eq("byp_wdata", {16'b0, fp_wdata_a_o}, 32'h3C00);
        check_eq("byp_haz_hold", {31'b0, hazard_o},  32'd1);
        idle(5'd3);
        check_eq("byp_haz_clr", {31'b0, hazard_o},   32'd0);

        // LSU beats FPU in the same cycle; FPU result follows next cycle.
        issue(5'd5);
        issue(5'd6);
        cycle(0, 0, 1, 5'd6, 16'h4200, 1, 5'd5, 16'h4000, 0, 0);
        check_eq("pri_lsu_addr", {27'b0, fp_waddr_a_o}, 32'd5);
        check_eq("pri_ready",    {31'b0, fpu_ready_o},  32'd1);
        idle(5'd0);
        check_eq("pri_fpu_addr", {27'b0, fp_waddr_a_o}, 32'd6);
        check_eq("pri_fpu_data", {16'b0, fp_wdata_a_o}, 32'h4200);

        // FIFO fills under sustained LSU traffic, then drains in order.
        issue(5'd10); issue(5'd11); issue(5'd12);
        issue(5'd20); issue(5'd21); issue(5'd22);
        cycle(0, 0, 1, 5'd20, 16'hA020, 1, 5'd10, 16'hB010, 0, 0);
        cycle(0, 0, 1, 5'd21, 16'hA021, 1, 5'd11, 16'hB011, 0, 0);
        check_eq("full_ready", {31'b0, fpu_ready_o}, 32'd0);
        cycle(0, 0, 1, 5'd22, 16'hA022, 1, 5'd12, 16'hB012, 0, 0);
        idle(5'd0);
        check_eq("drain0", {27'b0, fp_waddr_a_o}, 32'd20);
        idle(5'd0);
        check_eq("drain1", {27'b0, fp_waddr_a_o}, 32'd21);
        cycle(0, 0, 1, 5'd22, 16'hA022, 0, 0, 0, 0, 0);
        idle(5'd0);

        // rd=0 result is consumed silently.
        cycle(0, 0, 1, 5'd0, 16'h1234, 0, 0, 0, 0, 0);
        check_eq("rd0_we",  {31'b0, fp_we_a_o}, 32'd0);
        check_eq("rd0_err", {31'b0, err_o},     32'd0);
        idle(5'd0);

        // Protocol errors: write to non-pending rd, double issue.
        cycle(0, 0, 1, 5'd7, 16'h7777, 0, 0, 0, 0, 0);
        check_eq("err_nonpend", {31'b0, err_o}, 32'd1);
        idle(5'd0);
        check_eq("err_pulse_end", {31'b0, err_o}, 32'd0);
        issue(5'd3);
        issue(5'd3);
        check_eq("err_reissue", {31'b0, err_o}, 32'd1);
        cycle(0, 0, 1, 5'd3, 16'h0003, 0, 0, 0, 0, 0);
        idle(5'd0);

        // Reset with two entries buffered and a write in flight.
        issue(5'd8); issue(5'd9); issue(5'd14); issue(5'd15);
        cycle(0, 0, 1, 5'd8, 16'h0808, 1, 5'd14, 16'h1414, 0, 0);
        cycle(0, 0, 1, 5'd9, 16'h0909, 1, 5'd15, 16'h1515, 0, 0);
        check_eq("pre_rst_full", {31'b0, fpu_ready_o}, 32'd0);
        apply_reset(5'd8);
        for (int i = 1; i < 32; i++) begin
            idle(i[4:0]);
        end

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), 16'($urandom),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 16'($urandom),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_fp_writeback.md
IBEX_FP_WRITEBACK -- requirements
Module: ibex_fp_writeback

Interface
REQ-001 SHALL have parameter DataWidth, default 16, FP register width.
REQ-002 SHALL have parameter FifoDepth, default 2, FPU result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port issue_valid_i  input  1  FP op dispatched this cycle.
REQ-006 SHALL have port issue_rd_i  input  5  destination FP register of dispatched op.
REQ-007 SHALL have ports fpu_valid_i  input  1, fpu_ready_o  output  1  FPU result handshake.
REQ-008 SHALL have ports fpu_rd_i  input  5, fpu_result_i  input  DataWidth  FPU result payload.
REQ-009 SHALL have ports lsu_valid_i  input  1, lsu_rd_i  input  5, lsu_rdata_i  input  DataWidth  FP load return; no backpressure.
REQ-010 SHALL have ports fp_waddr_a_o  output  5, fp_wdata_a_o  output  DataWidth, fp_we_a_o  output  1  FP register file write port.
REQ-011 SHALL have ports rs1_addr_i  input  5, rs2_addr_i  input  5, hazard_o  output  1  operand-pending check.
REQ-012 SHALL have port err_o  output  1  single-cycle pulse on protocol violation.

Function
REQ-013 SHALL accept an FPU result when fpu_valid_i && fpu_ready_o; fpu_ready_o = FIFO not full, independent of fpu_valid_i.
REQ-014 SHALL push accepted FPU results ({rd, data}) into a FifoDepth-entry FIFO in order.
REQ-015 SHALL select each cycle: LSU if lsu_valid_i, else FIFO head if non-empty, else FPU input if handshaking with FIFO empty (bypass, no FIFO occupancy).
REQ-016 SHALL register the selected write: fp_we_a_o/waddr/wdata valid the cycle after selection (latency 1 from lsu_valid_i or FPU handshake with empty FIFO).
REQ-017 SHALL pop the FIFO head only in a cycle it is selected; LSU selection holds the head unchanged.
REQ-018 SHALL, on simultaneous push and pop, keep occupancy unchanged; pointers wrap modulo FifoDepth.
REQ-019 SHALL drive fp_we_a_o low for any selected write with rd == 0 (entry still consumed).
REQ-020 SHALL hold a 32-bit pending scoreboard: bit set on issue_valid_i (rd != 0), cleared on the edge where fp_we_a_o writes that rd.
REQ-021 SHALL, on same-edge set and clear of the same bit, leave the bit set.
REQ-022 SHALL drive hazard_o = pending[rs1_addr_i] | pending[rs2_addr_i], combinational; address 0 never hazards.
REQ-023 SHALL pulse err_o when a selected write targets rd != 0 whose pending bit is clear, or issue_valid_i targets an already-pending rd.
REQ-024 SHALL on err_o still perform the write and scoreboard update as specified.

Reset
REQ-025 SHALL, on rst_ni low, immediately clear FIFO pointers/occupancy, scoreboard, fp_we_a_o, fp_waddr_a_o, fp_wdata_a_o, err_o to 0; fpu_ready_o reads 1.
REQ-026 SHALL discard in-flight FIFO contents and pending registered write on reset mid-operation; no write issued after release until new input.

Structure
REQ-027 SHALL place DataWidth default constant and struct fp_wb_entry_t {rd[4:0], data[DataWidth-1:0]} in shared package ibex_fp_pkg.
REQ-028 SHALL implement the FIFO as sub-module ibex_fp_wb_fifo (parameters Depth, entry type; push/pop/full/empty).
REQ-029 SHALL contain no combinational path from fpu_valid_i to fpu_ready_o.

Verification
REQ-030 SHALL verify bypass: issue rd=3, FPU valid rd=3 data 0x3C00, empty FIFO -> next cycle we=1 waddr=3 wdata=0x3C00; hazard on rs1=3 high until that edge, low after.
REQ-031 SHALL verify priority: LSU rd=5 0x4000 and FPU rd=6 0x4200 same cycle -> cycle+1 writes rd5, cycle+2 writes rd6; fpu_ready_o stays 1.
REQ-032 SHALL verify full: LSU valid 3 consecutive cycles with FPU pushing -> after 2 pushes fpu_ready_o=0; FIFO drains in order once LSU idles.
REQ-033 SHALL verify rd=0: FPU result rd=0 -> entry consumed, fp_we_a_o stays 0, err_o stays 0.
REQ-034 SHALL verify errors: write to non-pending rd=7 -> err_o pulses one cycle; reissue to pending rd=3 -> err_o pulse.
REQ-035 SHALL verify reset mid-operation: FIFO holding 2 entries, rst_ni low -> outputs 0 immediately, no writes after release, scoreboard all clear.
